// File: rtl/nibble_serial_adder.sv
// Wide adder sequencer: feeds an external 4-bit adder one nibble per cycle.
// Optional OVERFLOW_FLAG_EN adds the registered out_ovf port.
module nibble_serial_adder #(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES,
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
    output logic [3:0]   add_a,
    output logic [3:0]   add_b,
    output logic         add_cin,
    input  logic [3:0]   add_sum,
    input  logic         add_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic         out_ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [IW-1:0] idx;
    logic [NIBBLES-1:0][3:0] opa, opb, res, res_nx;
    logic carry;
    logic [W-1:0] sum_q;
    logic cout_q;
    logic last;

    assign last = (idx == IW'(NIBBLES - 1));

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = 4'd0;
        add_b     = 4'd0;
        add_cin   = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                add_a   = opa[idx];
                add_b   = opb[idx];
                add_cin = carry;
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Kept apart from the decode above: add_sum loops back from add_a externally.
    always_comb begin
        res_nx      = res;
        res_nx[idx] = add_sum;
    end

`ifdef OVERFLOW_FLAG_EN
    logic ovf_q;
    assign out_ovf = ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            opa    <= '0;
            opb    <= '0;
            res    <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa   <= in_a;
                        opb   <= in_b;
                        carry <= in_cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    res   <= res_nx;
                    carry <= add_cout;
                    if (last) begin
                        sum_q  <= res_nx;
                        cout_q <= add_cout;
`ifdef OVERFLOW_FLAG_EN
                        ovf_q  <= (opa[NIBBLES-1][3] == opb[NIBBLES-1][3])
                               && (res_nx[NIBBLES-1][3] != opa[NIBBLES-1][3]);
`endif
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomised bench for nibble_serial_adder against a plain-arithmetic model.
// The 4-bit adder it drives is modelled here as a combinational add.
module tb_nibble_serial_adder;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, in_cin;
    logic [W-1:0] in_a, in_b;
    logic [3:0] add_a, add_b, add_sum;
    logic add_cin, add_cout;
    logic out_valid, out_ready, out_cout;
    logic [W-1:0] out_sum;
`ifdef OVERFLOW_FLAG_EN
    logic out_ovf;
`endif

    always #5 clk = ~clk;

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .in_cin(in_cin),
        .add_a(add_a),
        .add_b(add_b),
        .add_cin(add_cin),
        .add_sum(add_sum),
        .add_cout(add_cout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum(out_sum),
        .out_cout(out_cout)
`ifdef OVERFLOW_FLAG_EN
        ,
        .out_ovf(out_ovf)
`endif
    );

    logic [4:0] afull;
    assign afull    = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
    assign add_sum  = afull[3:0];
    assign add_cout = afull[4];

    int total = 0;
    int bad = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: cnt = RUN edges still to come, mv = result presented.
    int cnt = 0;
    bit mv = 0;
    bit chk_en = 0;
    logic [W-1:0] ma = '0, mb = '0;
    logic mc = 1'b0;
    logic [W:0] msum = '0;
    logic movf = 1'b0;

    function automatic logic [3:0] nib(logic [W-1:0] x, int k);
        logic [W-1:0] t;
        t = x >> (4 * k);
        return t[3:0];
    endfunction

    function automatic logic cin_at(int k);
        logic [63:0] m, s;
        m = (64'd1 << (4 * k)) - 64'd1;
        s = ({48'd0, ma} & m) + ({48'd0, mb} & m) + {63'd0, mc};
        s = s >> (4 * k);
        return s[0];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            cnt  = 0;
            mv   = 0;
            msum = '0;
            movf = 1'b0;
        end else if (mv) begin
            if (out_ready) mv = 0;
        end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                mv   = 1;
                msum = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
                movf = (ma[W-1] == mb[W-1]) && (msum[W-1] != ma[W-1]);
            end
        end else if (in_valid) begin
            ma  = in_a;
            mb  = in_b;
            mc  = in_cin;
            cnt = N;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int k;
            k = N - cnt;
            chk("in_ready", {31'd0, in_ready}, {31'd0, (cnt == 0 && !mv)});
            chk("out_valid", {31'd0, out_valid}, {31'd0, mv});
            chk("out_sum", {16'd0, out_sum}, {16'd0, msum[W-1:0]});
            chk("out_cout", {31'd0, out_cout}, {31'd0, msum[W]});
            chk("add_a", {28'd0, add_a}, (cnt > 0) ? {28'd0, nib(ma, k)} : 32'd0);
            chk("add_b", {28'd0, add_b}, (cnt > 0) ? {28'd0, nib(mb, k)} : 32'd0);
            chk("add_cin", {31'd0, add_cin}, (cnt > 0) ? {31'd0, cin_at(k)} : 32'd0);
`ifdef OVERFLOW_FLAG_EN
            chk("out_ovf", {31'd0, out_ovf}, {31'd0, movf});
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(string nm);
        int n;
        n = 0;
        while (!out_valid && n < 3 * N) begin
            step();
            n++;
        end
        if (!out_valid) chk({nm, "_valid_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_op(logic [W-1:0] a, logic [W-1:0] b, logic c,
                          int hold, output logic [W:0] r);
        int n;
        in_a     = a;
        in_b     = b;
        in_cin   = c;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 3 * N) begin
            step();
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        step();
        in_valid = 1'($urandom_range(0, 1));
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        in_cin   = 1'($urandom);
        wait_valid("op");
        in_valid = 1'b0;
        r = {out_cout, out_sum};
        repeat (hold) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [W:0] r;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_a = '0;
        in_b = '0;
        in_cin = 1'b0;
        @(posedge clk);
        chk_en = 1;
        step();
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_sum", {16'd0, out_sum}, 32'd0);

        run_op(16'h1234, 16'h4321, 1'b0, 0, r);
        chk("t1_sum", {15'd0, r}, 32'h05555);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1, r);
        chk("t2_sum", {15'd0, r}, 32'h10000);
        run_op(16'h0000, 16'h0000, 1'b1, 0, r);
        chk("t3a_sum", {15'd0, r}, 32'h00001);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 2, r);
        chk("t3b_sum", {15'd0, r}, 32'h1FFFF);

        // Backpressure with a competing operand pair offered
        in_a = 16'h1111;
        in_b = 16'h2222;
        in_cin = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_valid("bp");
        in_a = 16'hAAAA;
        in_b = 16'h1111;
        in_valid = 1'b1;
        repeat (5) begin
            chk("bp_hold_sum", {16'd0, out_sum}, 32'h3333);
            chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_idle_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        wait_valid("bp2");
        chk("bp2_sum", {15'd0, out_cout, out_sum}, 32'h0BBBB);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset after two RUN edges
        in_a = 16'h5678;
        in_b = 16'h1111;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rr_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rr_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rr_out_sum", {16'd0, out_sum}, 32'd0);
        chk("rr_add_a", {28'd0, add_a}, 32'd0);
        run_op(16'h00FF, 16'h0001, 1'b0, 0, r);
        chk("t5_sum", {15'd0, r}, 32'h00100);

        for (int i = 0; i < 120; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(0, 3) == 0) a = '1;
            if ($urandom_range(0, 3) == 0) b = '1;
            repeat ($urandom_range(0, 2)) step();
            run_op(a, b, 1'($urandom), $urandom_range(0, 3), r);
        end

        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
